// File: rtl/gpio_pad_bank_pkg.sv
// Drive-mode encodings and pad tristate polarity shared by the GPIO pad bank.
// Pure declarations: no latency, no backpressure.
package gpio_pad_pkg;

  typedef enum logic [1:0] {
    DRV_IN = 2'd0,
    DRV_PP = 2'd1,
    DRV_OD = 2'd2
  } drv_mode_e;

  // IOBUF T level that releases the pad (high-Z)
  localparam logic PAD_T_RELEASED = 1'b1;

  function automatic drv_mode_e drv_mode(input logic dir, input logic od);
    if (!dir) begin
      return DRV_IN;
    end else if (od) begin
      return DRV_OD;
    end else begin
      return DRV_PP;
    end
  endfunction

endpackage

// File: rtl/gpio_pad_bank_debounce.sv
// One pin: 2-FF synchroniser, optional debounce (GPIO_PAD_BANK_DEBOUNCE_EN), edge detect.
// Latency pad->in_lvl: 3 edges, or 2+DEBOUNCE_CYCLES with debounce; no backpressure.
module gpio_pad_debounce #(
  parameter logic RESET_VAL = 1'b1
`ifdef GPIO_PAD_BANK_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic in_lvl,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_PAD_BANK_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt;

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      in_lvl <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync2 == in_lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt    <= '0;
        in_lvl <= sync2;
        rise   <= sync2;
        fall   <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_lvl <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      in_lvl <= sync2;
      rise   <= sync2 & ~in_lvl;
      fall   <= ~sync2 & in_lvl;
    end
  end
`endif

endmodule

// File: rtl/gpio_pad_bank.sv
// N-pin pad controller: input/push-pull/open-drain drive, synchronised inputs, edge IRQs (debounce: GPIO_PAD_BANK_DEBOUNCE_EN).
// Drive 1 edge after config; pending 1 edge after edge pulse, o_irq 1 more; no backpressure.
module gpio_pad_bank
  import gpio_pad_pkg::*;
#(
  parameter int              N_PINS       = 8,
  parameter logic [N_PINS-1:0] IN_RESET_VAL = '1
`ifdef GPIO_PAD_BANK_DEBOUNCE_EN
  , parameter int            DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic              i_system_clk,
  input  logic              i_system_rst,
  input  logic [N_PINS-1:0] i_dir,
  input  logic [N_PINS-1:0] i_od,
  input  logic [N_PINS-1:0] i_out,
  output logic [N_PINS-1:0] o_pad_o,
  output logic [N_PINS-1:0] o_pad_t,
  input  logic [N_PINS-1:0] i_pad,
  output logic [N_PINS-1:0] o_in,
  output logic [N_PINS-1:0] o_rise,
  output logic [N_PINS-1:0] o_fall,
  input  logic [N_PINS-1:0] i_irq_rise_en,
  input  logic [N_PINS-1:0] i_irq_fall_en,
  input  logic [N_PINS-1:0] i_irq_clr,
  output logic [N_PINS-1:0] o_irq_pending,
  output logic              o_irq
);

  logic [N_PINS-1:0] pad_o_d;
  logic [N_PINS-1:0] pad_t_d;
  logic [N_PINS-1:0] irq_set;

  always_comb begin
    pad_o_d = '0;
    pad_t_d = {N_PINS{PAD_T_RELEASED}};
    for (int i = 0; i < N_PINS; i++) begin
      case (drv_mode(i_dir[i], i_od[i]))
        DRV_PP: begin
          pad_t_d[i] = ~PAD_T_RELEASED;
          pad_o_d[i] = i_out[i];
        end
        // Open-drain only ever drives low: out=1 releases the pad to the pull-up
        DRV_OD:  pad_t_d[i] = i_out[i];
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_system_clk) begin
    if (!i_system_rst) begin
      o_pad_o <= '0;
      o_pad_t <= {N_PINS{PAD_T_RELEASED}};
    end else begin
      o_pad_o <= pad_o_d;
      o_pad_t <= pad_t_d;
    end
  end

  for (genvar g = 0; g < N_PINS; g++) begin : g_pin
    gpio_pad_debounce #(
      .RESET_VAL(IN_RESET_VAL[g])
`ifdef GPIO_PAD_BANK_DEBOUNCE_EN
      , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
    ) u_pin (
      .clk   (i_system_clk),
      .rst_n (i_system_rst),
      .pad   (i_pad[g]),
      .in_lvl(o_in[g]),
      .rise  (o_rise[g]),
      .fall  (o_fall[g])
    );
  end

  assign irq_set = (o_rise & i_irq_rise_en) | (o_fall & i_irq_fall_en);

  // Set has priority so an edge arriving with a clear is never lost
  always_ff @(posedge i_system_clk) begin
    if (!i_system_rst) begin
      o_irq_pending <= '0;
      o_irq         <= 1'b0;
    end else begin
      o_irq_pending <= (o_irq_pending & ~i_irq_clr) | irq_set;
      o_irq         <= |o_irq_pending;
    end
  end

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Directed + random bench for gpio_pad_bank against a rule-level reference model.
// Debounce checks are built only when GPIO_PAD_BANK_DEBOUNCE_EN is defined.
module tb_gpio_pad_bank;

`ifdef GPIO_PAD_BANK_DEBOUNCE_EN
  localparam int DCE = 16;
`else
  localparam int DCE = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dir, od, out, pad, ren, fen, clr;
  logic [7:0] pad_o, pad_t, in_lvl, rise, fall, pend;
  logic       irq;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_o, m_t, m_in, m_rise, m_fall, m_pend;
  logic       m_irq;
  logic [7:0] padq[$];
  int         run[8];

  always #5 clk = ~clk;

  gpio_pad_bank #(.N_PINS(8), .IN_RESET_VAL(8'hFF)) dut (
    .i_system_clk (clk),
    .i_system_rst (rst),
    .i_dir        (dir),
    .i_od         (od),
    .i_out        (out),
    .o_pad_o      (pad_o),
    .o_pad_t      (pad_t),
    .i_pad        (pad),
    .o_in         (in_lvl),
    .o_rise       (rise),
    .o_fall       (fall),
    .i_irq_rise_en(ren),
    .i_irq_fall_en(fen),
    .i_irq_clr    (clr),
    .o_irq_pending(pend),
    .o_irq        (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: pin level seen by the input logic is the pad sampled two edges earlier;
  // it becomes o_in once it has differed from o_in for DCE consecutive edges.
  task automatic model_edge();
    logic [7:0] cur;
    if (!rst) begin
      m_o = 8'h00; m_t = 8'hFF; m_in = 8'hFF;
      m_rise = 8'h00; m_fall = 8'h00; m_pend = 8'h00; m_irq = 1'b0;
      padq = '{8'hFF, 8'hFF};
      for (int i = 0; i < 8; i++) run[i] = 0;
    end else begin
      m_irq  = |m_pend;
      m_pend = (m_pend & ~clr) | (m_rise & ren) | (m_fall & fen);
      padq.push_back(pad);
      cur = padq.pop_front();
      m_rise = 8'h00;
      m_fall = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (cur[i] != m_in[i]) begin
          run[i]++;
          if (run[i] >= DCE) begin
            m_in[i] = cur[i];
            m_rise[i] = cur[i];
            m_fall[i] = ~cur[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      for (int i = 0; i < 8; i++) begin
        if (!dir[i])     begin m_t[i] = 1'b1;   m_o[i] = 1'b0;   end
        else if (!od[i]) begin m_t[i] = 1'b0;   m_o[i] = out[i]; end
        else             begin m_t[i] = out[i]; m_o[i] = 1'b0;   end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("pad_o", pad_o, m_o);
    chk("pad_t", pad_t, m_t);
    chk("in", in_lvl, m_in);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("pending", pend, m_pend);
    chk("irq", irq, m_irq);
  endtask

  initial begin
    rst = 1'b0; pad = 8'hFF;
    dir = 8'h00; od = 8'h00; out = 8'h00;
    ren = 8'h00; fen = 8'h00; clr = 8'h00;
    repeat (3) tick();
    chk("rst_pad_t", pad_t, 8'hFF);
    chk("rst_in", in_lvl, 8'hFF);
    chk("rst_pad_o", pad_o, 8'h00);

    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("no_edge_after_rst", rise | fall, 8'h00);
    end

    // Push-pull then open-drain on pin 0
    dir = 8'h01; out = 8'h01;
    tick();
    chk("pp_o0", pad_o[0], 1'b1);
    chk("pp_t0", pad_t[0], 1'b0);
    od = 8'h01;
    tick();
    chk("od_o0", pad_o[0], 1'b0);
    chk("od_t0_rel", pad_t[0], 1'b1);
    out = 8'h00;
    tick();
    chk("od_t0_low", pad_t[0], 1'b0);

    // Falling edge on pin 3
    fen = 8'h08;
    pad[3] = 1'b0;
    repeat (DCE + 1) tick();
    chk("fall3_early", fall[3], 1'b0);
    tick();
    chk("fall3_pulse", fall[3], 1'b1);
    tick();
    chk("fall3_single", fall[3], 1'b0);
    chk("pend3_set", pend[3], 1'b1);
    tick();
    chk("irq_set", irq, 1'b1);

    // New fall on pin 3 coinciding with a clear
    pad[3] = 1'b1;
    repeat (DCE + 4) tick();
    pad[3] = 1'b0;
    repeat (DCE + 2) tick();
    chk("fall3_again", fall[3], 1'b1);
    clr = 8'h08;
    tick();
    clr = 8'h00;
    chk("set_wins", pend[3], 1'b1);
    clr = 8'h08;
    tick();
    clr = 8'h00;
    chk("clr_alone", pend[3], 1'b0);
    tick();
    chk("irq_clr", irq, 1'b0);

    // Randomised traffic with occasional mid-run reset
    for (int k = 0; k < 600; k++) begin
      dir = 8'($urandom); od = 8'($urandom); out = 8'($urandom);
      ren = 8'($urandom); fen = 8'($urandom);
      clr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 4 * DCE) == 0) pad[$urandom_range(0, 7)] ^= 1'b1;
      rst = ($urandom_range(0, 150) != 0);
      tick();
    end
    rst = 1'b1;
    clr = 8'h00;

`ifdef GPIO_PAD_BANK_DEBOUNCE_EN
    pad = 8'hFF; clr = 8'hFF;
    repeat (3 * DCE) tick();
    clr = 8'h00;
    // 15-cycle glitch is rejected
    pad[2] = 1'b0;
    repeat (15) tick();
    pad[2] = 1'b1;
    repeat (DCE + 4) tick();
    chk("glitch15_in", in_lvl[2], 1'b1);
    // 17-cycle low is accepted on the 18th edge
    pad[2] = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("low17_hold", in_lvl[2], 1'b1);
    end
    pad[2] = 1'b1;
    tick();
    chk("low17_in", in_lvl[2], 1'b0);
    chk("low17_fall", fall[2], 1'b1);
    repeat (DCE + 4) tick();
    // Reset during a debounce in progress
    pad[2] = 1'b0;
    repeat (12) tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_in", in_lvl, 8'hFF);
    chk("mid_rst_pend", pend, 8'h00);
    rst = 1'b1;
    pad[2] = 1'b1;
    repeat (DCE + 4) tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
